// File: rtl/dp_scheduler.sv
// Round-robin front end that shares one point-multiplication core among NUM_REQ requesters.
// Optional watchdog on the core result is enabled by defining DP_TIMEOUT_EN.
module dp_scheduler #(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Px,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Py,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_k,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_Rx,
  output logic [DATA_WIDTH-1:0]         rsp_Ry,
  output logic                          rsp_err,
  output logic                          core_in_valid,
  output logic [DATA_WIDTH-1:0]         core_Px,
  output logic [DATA_WIDTH-1:0]         core_Py,
  output logic [DATA_WIDTH-1:0]         core_k,
  input  logic [DATA_WIDTH-1:0]         core_Rx,
  input  logic [DATA_WIDTH-1:0]         core_Ry,
  input  logic                          core_out_valid,
  output logic                          busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("dp_scheduler: unsupported parameter value");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d, grant_q, grant_d;
  logic [DATA_WIDTH-1:0] px_q, px_d, py_q, py_d, k_q, k_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [IdxW-1:0]       pick;
  logic                  pick_vld;
  logic [IdxW:0]         cand;
`ifdef DP_TIMEOUT_EN
  logic [31:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  // First pending requester at or above ptr_q, wrapping at NUM_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NUM_REQ)) cand = cand - (IdxW+1)'(NUM_REQ);
      if (!pick_vld && req_valid[cand[IdxW-1:0]]) begin
        pick     = cand[IdxW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    px_d    = px_q;
    py_d    = py_q;
    k_d     = k_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
`ifdef DP_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == IdxW'(i)) begin
              px_d = req_Px[i*DATA_WIDTH +: DATA_WIDTH];
              py_d = req_Py[i*DATA_WIDTH +: DATA_WIDTH];
              k_d  = req_k[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef DP_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (core_out_valid) begin
          rx_d    = core_Rx;
          ry_d    = core_Ry;
`ifdef DP_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end
`ifdef DP_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == TIMEOUT_CYCLES) begin
            rx_d    = '0;
            ry_d    = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
`endif
      end
      StResp: begin
        if (rsp_ready[grant_q]) begin
          ptr_d   = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      k_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
`ifdef DP_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      px_q    <= px_d;
      py_q    <= py_d;
      k_q     <= k_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
`ifdef DP_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == StIdle && pick_vld) req_ready[pick] = 1'b1;
    if (state_q == StResp) rsp_valid[grant_q] = 1'b1;
  end

  assign core_in_valid = (state_q == StIssue);
  assign busy          = (state_q != StIdle);
  assign core_Px       = px_q;
  assign core_Py       = py_q;
  assign core_k        = k_q;
  assign rsp_Rx        = rx_q;
  assign rsp_Ry        = ry_q;
`ifdef DP_TIMEOUT_EN
  assign rsp_err       = err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dp_scheduler.sv
// Randomized scoreboard bench for dp_scheduler with a behavioural core stub and
// a round-robin reference model; ends with directed reset and pointer cases.
module tb_dp_scheduler;
  localparam int unsigned DW = 64;
  localparam int unsigned N  = 4;

  typedef logic [DW-1:0] word_t;
  typedef struct {
    int unsigned idx;
    word_t       px, py, k;
  } job_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_Px, req_Py, req_k;
  word_t           rsp_Rx, rsp_Ry, core_Px, core_Py, core_k, core_Rx, core_Ry;
  logic            rsp_err, core_in_valid, core_out_valid, busy;

  always #5 clk = ~clk;

  dp_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_Px(req_Px), .req_Py(req_Py), .req_k(req_k),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_Rx(rsp_Rx), .rsp_Ry(rsp_Ry), .rsp_err(rsp_err),
    .core_in_valid(core_in_valid),
    .core_Px(core_Px), .core_Py(core_Py), .core_k(core_k),
    .core_Rx(core_Rx), .core_Ry(core_Ry), .core_out_valid(core_out_valid),
    .busy(busy)
  );

  int unsigned total = 0, bad = 0, n_done = 0, last_acc = N;
  job_t        exp_q[$];
  int unsigned model_ptr = 0;
  bit          in_resp = 0, issue_exp = 0;
  logic [N-1:0] acc_mask = '0;
  bit          gen_en = 0, slow_core = 0, genuine = 0, job = 0;
  word_t       jpx, jpy, jk;
  int unsigned lat = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
    end
  endtask

  // The stub core's "point multiply": any fixed function of the operands will do.
  function automatic word_t rx_of(input word_t px, input word_t k);
    return px ^ k;
  endfunction
  function automatic word_t ry_of(input word_t py, input word_t k);
    return py + k;
  endfunction

  function automatic int unsigned rr_pick(input logic [N-1:0] pend, input int unsigned from);
    for (int unsigned i = 0; i < N; i++) if (pend[(from + i) % N]) return (from + i) % N;
    return N;
  endfunction

  // Reference model + scoreboard monitor.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy, exp_rsp;
    int unsigned  g;
    job_t         j;
    if (!rst_n) begin
      exp_q.delete();
      model_ptr = 0;
      in_resp   = 0;
      issue_exp = 0;
      acc_mask  = '0;
    end else begin
      exp_rdy = '0;
      g       = N;
      if (exp_q.size() == 0 && req_valid != '0) begin
        g          = rr_pick(req_valid, model_ptr);
        exp_rdy[g] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, exp_q.size() != 0);
      chk("core_in_valid", core_in_valid, issue_exp);
      if (issue_exp && exp_q.size() != 0) begin
        chk("core_Px", core_Px, exp_q[0].px);
        chk("core_Py", core_Py, exp_q[0].py);
        chk("core_k", core_k, exp_q[0].k);
      end
      exp_rsp = '0;
      if (in_resp) exp_rsp[exp_q[0].idx] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (in_resp) begin
        chk("rsp_Rx", rsp_Rx, rx_of(exp_q[0].px, exp_q[0].k));
        chk("rsp_Ry", rsp_Ry, ry_of(exp_q[0].py, exp_q[0].k));
        chk("rsp_err", rsp_err, 0);
      end
      issue_exp = 0;
      if (in_resp && rsp_ready[exp_q[0].idx]) begin
        model_ptr = (exp_q[0].idx + 1) % N;
        void'(exp_q.pop_front());
        in_resp = 0;
        n_done++;
      end else if (!in_resp && exp_q.size() != 0 && core_out_valid && genuine) begin
        in_resp = 1;
      end
      acc_mask = req_valid & req_ready;
      if (g < N && req_ready[g]) begin
        j.idx = g;
        j.px  = req_Px[g*DW +: DW];
        j.py  = req_Py[g*DW +: DW];
        j.k   = req_k[g*DW +: DW];
        exp_q.push_back(j);
        issue_exp = 1;
        last_acc  = g;
      end
    end
  end

  // Core stub: captures on launch, answers after a random latency, and
  // throws spurious result pulses while it has no job in flight.
  always @(negedge clk) begin
    if (rst_n && core_in_valid === 1'b1) begin
      job = 1;
      jpx = core_Px;
      jpy = core_Py;
      jk  = core_k;
      lat = slow_core ? 60 : $urandom_range(0, 6);
    end
  end

  initial begin
    core_out_valid = 1'b0;
    core_Rx = '0;
    core_Ry = '0;
    forever begin
      @(posedge clk); #1;
      core_out_valid = 1'b0;
      genuine        = 0;
      if (job) begin
        if (lat == 0) begin
          core_out_valid = 1'b1;
          genuine        = 1;
          core_Rx        = rx_of(jpx, jk);
          core_Ry        = ry_of(jpy, jk);
          job            = 0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        core_out_valid = 1'b1;
        core_Rx        = {$urandom, $urandom};
        core_Ry        = {$urandom, $urandom};
      end
    end
  end

  task automatic drive();
    logic [31:0] r;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) req_valid[i] = 1'b0;
      if (gen_en && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_Px[i*DW +: DW] = {$urandom, $urandom};
        req_Py[i*DW +: DW] = {$urandom, $urandom};
        req_k[i*DW +: DW]  = {$urandom, $urandom};
        req_valid[i]       = 1'b1;
      end
    end
    acc_mask  = '0;
    r         = $urandom;
    rsp_ready = r[N-1:0];
  endtask

  task automatic post_req(input int i);
    req_Px[i*DW +: DW] = {$urandom, $urandom};
    req_Py[i*DW +: DW] = {$urandom, $urandom};
    req_k[i*DW +: DW]  = {$urandom, $urandom};
    req_valid[i]       = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_Rx"}, rsp_Rx, 0);
    chk({tag, "_rsp_Ry"}, rsp_Ry, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_core_in_valid"}, core_in_valid, 0);
    chk({tag, "_core_Px"}, core_Px, 0);
    chk({tag, "_core_Py"}, core_Py, 0);
    chk({tag, "_core_k"}, core_k, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int cyc = 0;
    while (n_done < target && cyc < 300) begin
      @(posedge clk); #1;
      drive();
      cyc++;
    end
    chk({tag, "_timeout"}, n_done >= target, 1);
  endtask

  initial begin
    int          cyc;
    int unsigned base;
    rst_n     = 1'b0;
    req_valid = '0;
    req_Px    = '0;
    req_Py    = '0;
    req_k     = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    gen_en = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      drive();
    end
    gen_en = 0;
    cyc = 0;
    while ((exp_q.size() != 0 || req_valid != '0) && cyc < 500) begin
      @(posedge clk); #1;
      drive();
      cyc++;
    end
    chk("drain_timeout", cyc < 500, 1);
    chk("progress", n_done >= 100, 1);

    // Reset during WAIT aborts the job and restarts arbitration from requester 0.
    slow_core = 1;
    post_req(3);
    cyc = 0;
    while (!job && cyc < 20) begin
      @(posedge clk); #1;
      drive();
      cyc++;
    end
    chk("mid_reset_launch", job, 1);
    repeat (3) begin
      @(posedge clk); #1;
      drive();
    end
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    job       = 0;
    slow_core = 0;
    @(negedge clk);
    check_zero("after_reset");
    @(posedge clk); #1;
    base = n_done;
    post_req(3);
    wait_done(base + 1, "req3_after_reset");
    chk("req3_grant", last_acc, 3);

    // After requester 2 finishes, 3 outranks 1.
    post_req(2);
    wait_done(base + 2, "req2_alone");
    post_req(1);
    post_req(3);
    cyc = 0;
    while (req_valid[3] && cyc < 20) begin
      @(posedge clk); #1;
      drive();
      cyc++;
    end
    chk("rr_after2_grant", last_acc, 3);
    wait_done(base + 4, "rr_after2_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dp_scheduler.md
# dp_scheduler

Round-robin scheduler that shares one scalar point-multiplication core (R = k·P, `DATA_WIDTH`-bit affine coordinates) among `NUM_REQ` requesters. It accepts one request at a time over a valid/ready handshake and launches the core with a single-cycle `in_valid` pulse. It waits for the core's `out_valid`, then returns Rx/Ry to the originating requester over a valid/ready response channel. It sits directly in front of the dP core in the ECC top level.

## Interface
Parameters:
- `DATA_WIDTH`, 256, coordinate/scalar width
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 2000000, watchdog limit (used only with `DP_TIMEOUT_EN`)

Ports:
- `clk`  in  1  — single clock, rising-edge
- `rst_n`  in  1  — synchronous, active-low reset
- `req_valid`  in  NUM_REQ  — request pending, one bit per requester
- `req_ready`  out  NUM_REQ  — request accepted (one-hot or zero)
- `req_Px`, `req_Py`, `req_k`  in  NUM_REQ*DATA_WIDTH  — packed operands; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `rsp_valid`  out  NUM_REQ  — result available (one-hot or zero)
- `rsp_ready`  in  NUM_REQ  — requester takes result
- `rsp_Rx`, `rsp_Ry`  out  DATA_WIDTH  — shared result bus
- `rsp_err`  out  1  — result invalid (timeout)
- `core_in_valid`  out  1  — launch pulse to core
- `core_Px`, `core_Py`, `core_k`  out  DATA_WIDTH  — core operands
- `core_Rx`, `core_Ry`  in  DATA_WIDTH  — core result
- `core_out_valid`  in  1  — core result valid
- `busy`  out  1  — state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first index with `req_valid` set, searching upward from `ptr`, wrapping at NUM_REQ.
  - `req_ready[grant]` is asserted combinationally.
  - On that cycle, latch the grant index and the three operands, then go to ISSUE.
  - No `req_valid` set: remain in IDLE.
- ISSUE: `core_in_valid`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `core_out_valid`=1, capture `core_Rx`/`core_Ry` into the result registers and go to RESP.
- RESP: `rsp_valid[grant]`=1, holding Rx/Ry/err stable.
  - When `rsp_ready[grant]`=1: set `ptr` = (grant+1) mod NUM_REQ and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `core_Px`/`core_Py`/`core_k` are driven from the latched operand registers at all times.
- `core_out_valid` outside WAIT is ignored.
- Requesters hold `req_valid` and operands stable until `req_ready`. Dropping `req_valid` before grant is legal and means no request.
- No arithmetic is performed. Operands and results pass through unmodified, full width.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, `ptr`=0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_Rx`, `rsp_Ry`, `rsp_err`, `core_in_valid`, core operands, `busy`.
- Reset mid-operation aborts the job; no response is issued. The core is reset by the same `rst_n`.
- Accept at cycle t → `core_in_valid` at t+1.
- `core_out_valid` at cycle c → `rsp_valid` at c+1.
- Minimum request-to-response latency is core latency + 2 cycles.
- Back-to-back: the response handshake at cycle r returns to IDLE. The next `req_ready` is at r+1 at the earliest (one bubble).
- `req_ready` is only ever asserted in IDLE. At most one bit of `req_ready` and of `rsp_valid` is set at a time.

## Configuration
- `DP_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` without `core_out_valid`, go to RESP with `rsp_err`=1 and `rsp_Rx`=`rsp_Ry`=0.
  - A `core_out_valid` in the same cycle as expiry wins: normal result, `rsp_err`=0.
- Not defined:
  - No counter; WAIT persists indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Single requester 1 with a golden `dotProduct.txt` vector, real core → `core_in_valid` high for exactly 1 cycle, 1 cycle after accept; `rsp_valid`=4'b0010 one cycle after `core_out_valid`; Rx/Ry match golden; `rsp_err`=0.
- All four `req_valid` asserted from reset, `rsp_ready` tied high → service order 0,1,2,3; each response matches its own golden vector.
- After requester 2 completes (`ptr`=3), requesters 1 and 3 pending → 3 granted before 1.
- Hold `rsp_ready` low 5 cycles in RESP while another requester is pending → `rsp_valid`, `rsp_Rx`, `rsp_Ry` stable; `req_ready`=0 throughout.
- Assert `rst_n`=0 for 1 cycle during WAIT → next cycle all outputs 0, `busy`=0; the subsequent request on requester 3 is served normally with `ptr` starting at 0.
- `DP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, stub core that never responds → `rsp_valid` 17 cycles after ISSUE with `rsp_err`=1 and Rx=Ry=0. The same case without the macro stays in WAIT, `busy`=1.
